// File: rtl/wave_classify_ctrl.sv
// Windowed comparator-edge timing classifier with vote-filtered select output.
// Captures the first synchronized rise per window, classifies it, and updates sel_sig after AGREE agreeing windows.
module wave_classify_ctrl #(
    parameter int WIN_LEN = 1000,
    parameter int CNT_W   = 10,
    parameter int AGREE   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cmp1_sig,
    output logic             win_start,
    output logic [CNT_W-1:0] meas_cnt,
    output logic [3:0]       sel_sig,
    output logic             sel_valid,
    output logic             sel_change,
    output logic             no_edge
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HOLD
    } state_e;

    localparam logic [2:0]       AGR  = 3'(AGREE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_LEN - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cap_q;
    logic             s1_q;
    logic             s2_q;
    logic             prev_q;
    logic [3:0]       cand_q;
    logic [2:0]       agree_q;

    logic             rise;
    logic             last;
    logic             hit;
    logic             have;
    logic [CNT_W-1:0] cval;
    logic [3:0]       cls;
    logic [3:0]       cand_d;
    logic [2:0]       agree_d;

    function automatic logic [3:0] classify(input logic [CNT_W-1:0] v);
        int unsigned cv;
        logic [3:0]  r;
        cv = 32'(v);
        r  = 4'b0000;
        unique case (1'b1)
            (cv <= 32'd40):                  r = 4'b0001;
            (cv >= 32'd220 && cv <= 32'd270): r = 4'b0010;
            (cv >= 32'd410 && cv <= 32'd465): r = 4'b1000;
            (cv >= 32'd485 && cv <= 32'd520): r = 4'b0100;
            default:                          r = 4'b0000;
        endcase
        return r;
    endfunction

    assign rise = s2_q & ~prev_q;
    assign last = (cnt_q == LAST);
    assign hit  = (state_q == ARM) && rise;
    assign have = (state_q == HOLD) || hit;
    assign cval = hit ? cnt_q : cap_q;
    assign cls  = classify(cval);

    assign win_start = (state_q != IDLE) && en && (cnt_q == '0);

    always_comb begin
        cand_d  = cand_q;
        agree_d = agree_q;
        if (!have || cls == 4'b0000) begin
            cand_d  = 4'b0000;
            agree_d = 3'd0;
        end else if (cls == cand_q) begin
            agree_d = (agree_q >= AGR) ? AGR : agree_q + 3'd1;
        end else begin
            cand_d  = cls;
            agree_d = 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cap_q      <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            prev_q     <= 1'b0;
            cand_q     <= 4'b0000;
            agree_q    <= 3'd0;
            meas_cnt   <= '0;
            sel_sig    <= 4'b0000;
            sel_valid  <= 1'b0;
            sel_change <= 1'b0;
            no_edge    <= 1'b0;
        end else begin
            s1_q       <= cmp1_sig;
            s2_q       <= s1_q;
            prev_q     <= s2_q;
            sel_change <= 1'b0;
            no_edge    <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                cand_q  <= 4'b0000;
                agree_q <= 3'd0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= ARM;
                        cnt_q   <= '0;
                    end
                    ARM, HOLD: begin
                        cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
                        if (hit) begin
                            cap_q   <= cnt_q;
                            state_q <= HOLD;
                        end
                        // Window evaluation; a rise in this same cycle still counts.
                        if (last) begin
                            state_q <= ARM;
                            cand_q  <= cand_d;
                            agree_q <= agree_d;
                            if (have) meas_cnt <= cval;
                            else      no_edge  <= 1'b1;
                            if (agree_d == AGR && cand_d != sel_sig) begin
                                sel_sig    <= cand_d;
                                sel_valid  <= 1'b1;
                                sel_change <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
